// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: address width, reset PC, stack depth and
// the PC sequencer state encoding.
package cpu_pkg;

    localparam int          AW          = 8;
    localparam logic [7:0]  RESET_PC    = 8'h00;
    localparam int          STACK_DEPTH = 15;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        FAULT    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_stack_depth_ctr.sv
// Occupancy tracker for the return-address stack. Counts 0..DEPTH,
// saturating at both ends, and flags full/empty for the sequencer.
module stack_depth_ctr #(
    parameter  int DEPTH = 15,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam logic [DW-1:0] MAX = DW'(DEPTH);

    logic [DW-1:0] depth;

    // Up on push, down on pop; the sequencer never asserts both together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            depth <= '0;
        else if (inc && !full)
            depth <= depth + 1'b1;
        else if (dec && !empty)
            depth <= depth - 1'b1;
    end

    assign full  = (depth == MAX);
    assign empty = (depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer. Chooses the next PC from
// sequential / jump / call / return / late redirect, issues push/pop
// commands to the return-address stack and marks invalid fetch slots.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              AW          = cpu_pkg::AW,
    parameter int              STACK_DEPTH = cpu_pkg::STACK_DEPTH,
    parameter logic [AW-1:0]   RESET_PC    = AW'(cpu_pkg::RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          is_jump,
    input  logic          is_call,
    input  logic          is_ret,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] ret_addr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pcp1,
    output logic          stack_op,
    output logic          call_ret,
    output logic          bubble,
    output logic          stack_fault
);

    seq_state_t state;
    logic       full, empty;
    logic       in_run, do_ret, do_call;

    // Return address for CALL and the sequential successor.
    assign pcp1 = pc + 1'b1;

    // Stack moves only for accepted ops: redirect kills decode, RET beats CALL.
    assign in_run  = (state == RUN) && !redirect;
    assign do_ret  = in_run && is_ret && !empty;
    assign do_call = in_run && !is_ret && is_call && !full;

    stack_depth_ctr #(.DEPTH(STACK_DEPTH)) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_call),
        .dec   (do_ret),
        .full  (full),
        .empty (empty)
    );

    // Next-PC selection and sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            stack_op    <= 1'b0;
            call_ret    <= 1'b0;
            bubble      <= 1'b1;
            stack_fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    stack_op <= 1'b0;
                    if (redirect) begin
                        pc     <= redirect_pc;
                        bubble <= 1'b1;
                    end else if (is_ret) begin
                        bubble <= 1'b1;
                        if (empty) begin
                            state       <= FAULT;
                            stack_fault <= 1'b1;
                        end else begin
                            // Pop now; the stack's registered read lands next cycle.
                            stack_op <= 1'b1;
                            call_ret <= 1'b0;
                            state    <= RET_WAIT;
                        end
                    end else if (is_call) begin
                        bubble <= 1'b1;
                        if (full) begin
                            state       <= FAULT;
                            stack_fault <= 1'b1;
                        end else begin
                            stack_op <= 1'b1;
                            call_ret <= 1'b1;
                            pc       <= target;
                        end
                    end else if (is_jump) begin
                        pc     <= target;
                        bubble <= 1'b1;
                    end else if (stall) begin
                        bubble <= 1'b0;
                    end else begin
                        pc     <= pcp1;
                        bubble <= 1'b0;
                    end
                end
                RET_WAIT: begin
                    // A late redirect overrides the return target; the pop stands.
                    pc       <= redirect ? redirect_pc : ret_addr;
                    bubble   <= 1'b1;
                    stack_op <= 1'b0;
                    state    <= RUN;
                end
                default: begin
                    // FAULT is terminal until reset.
                    state       <= FAULT;
                    stack_fault <= 1'b1;
                    bubble      <= 1'b1;
                    stack_op    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected outputs are queued as each
// stimulus step is driven and compared after the following clock edge.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, redirect, is_jump, is_call, is_ret;
    logic [7:0] redirect_pc, target, ret_addr;
    logic [7:0] pc, pcp1;
    logic       stack_op, call_ret, bubble, stack_fault;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] pc;
        logic       bub;
        logic       sop;
        logic       cr;
        logic       flt;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .is_jump     (is_jump),
        .is_call     (is_call),
        .is_ret      (is_ret),
        .target      (target),
        .ret_addr    (ret_addr),
        .pc          (pc),
        .pcp1        (pcp1),
        .stack_op    (stack_op),
        .call_ret    (call_ret),
        .bubble      (bubble),
        .stack_fault (stack_fault)
    );

    always #5 clk = ~clk;

    function automatic exp_t E(input logic [7:0] p, input logic b, input logic s,
                               input logic c, input logic f);
        exp_t e;
        e.pc = p; e.bub = b; e.sop = s; e.cr = c; e.flt = f;
        return e;
    endfunction

    task automatic drv(input logic r, input logic [7:0] rpc, input logic j,
                       input logic c, input logic rt, input logic [7:0] tg,
                       input logic st, input logic [7:0] ra);
        redirect = r; redirect_pc = rpc; is_jump = j; is_call = c;
        is_ret = rt; target = tg; stall = st; ret_addr = ra;
    endtask

    // Pop the oldest expectation and compare it to the outputs now.
    task automatic check_out();
        exp_t        e;
        string       tag;
        logic [11:0] obs, expv;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
            return;
        end
        e   = sb.pop_front();
        tag = tq.pop_front();
        obs  = {pc, bubble, stack_op, stack_op & call_ret, stack_fault};
        expv = {e.pc, e.bub, e.sop, e.sop & e.cr, e.flt};
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got pc=%h bub=%b sop=%b cr=%b flt=%b, expected pc=%h bub=%b sop=%b cr=%b flt=%b",
                   tag, pc, bubble, stack_op, call_ret, stack_fault,
                   e.pc, e.bub, e.sop, e.cr, e.flt);
        end
    endtask

    // Queue the expected result of the currently driven inputs, then clock.
    task automatic tick(input string tag, input exp_t e);
        sb.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic now_chk(input string tag, input exp_t e);
        sb.push_back(e);
        tq.push_back(tag);
        check_out();
    endtask

    task automatic chk_pcp1(input string tag, input logic [7:0] e);
        tests++;
        assert (pcp1 === e) else begin
            fails++;
            $error("FAIL %s: got pcp1=%h, expected %h", tag, pcp1, e);
        end
    endtask

    task automatic do_reset(input string tag);
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        rst_n = 1'b0;
        #2;
        now_chk(tag, E(8'h00, 1, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        #12;
        now_chk("reset", E(8'h00, 1, 0, 0, 0));
        rst_n = 1'b1;

        // free-running after reset
        tick("seq1", E(8'h01, 0, 0, 0, 0));
        tick("seq2", E(8'h02, 0, 0, 0, 0));
        tick("seq3", E(8'h03, 0, 0, 0, 0));

        // call from pc=10 to 40
        drv(1, 8'h10, 0, 0, 0, 8'h00, 0, 8'h00);
        tick("redir10", E(8'h10, 1, 0, 0, 0));
        drv(0, 8'h00, 0, 1, 0, 8'h40, 0, 8'h00);
        chk_pcp1("pcp1_at10", 8'h11);
        tick("call40", E(8'h40, 1, 1, 1, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        for (int i = 1; i <= 5; i++)
            tick("seq4x", E(8'h40 + 8'(i), 0, 0, 0, 0));

        // return at 45: pop pulse, wait cycle (stall ignored), then 11
        drv(0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00);
        tick("ret_pop", E(8'h45, 1, 1, 0, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h11);
        tick("ret_wait", E(8'h11, 1, 0, 0, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        tick("after_ret", E(8'h12, 0, 0, 0, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00);
        tick("stall", E(8'h12, 0, 0, 0, 0));

        // wrap at FF
        drv(0, 8'h00, 1, 0, 0, 8'hFF, 0, 8'h00);
        tick("jumpFF", E(8'hFF, 1, 0, 0, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        chk_pcp1("pcp1_atFF", 8'h00);
        tick("wrap", E(8'h00, 0, 0, 0, 0));

        // call&ret together: RET wins; redirect overrides RET_WAIT target
        drv(0, 8'h00, 0, 1, 0, 8'h60, 0, 8'h00);
        tick("call60", E(8'h60, 1, 1, 1, 0));
        drv(0, 8'h00, 0, 1, 1, 8'h70, 0, 8'h00);
        tick("callret", E(8'h60, 1, 1, 0, 0));
        drv(1, 8'h33, 0, 0, 0, 8'h00, 0, 8'h77);
        tick("redir_in_wait", E(8'h33, 1, 0, 0, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        tick("after_redir", E(8'h34, 0, 0, 0, 0));

        // redirect discards call; depth still 0 so RET then faults
        drv(1, 8'h20, 0, 1, 0, 8'h50, 0, 8'h00);
        tick("redir_call", E(8'h20, 1, 0, 0, 0));
        drv(0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00);
        tick("underflow", E(8'h20, 1, 0, 0, 1));
        drv(0, 8'h00, 1, 0, 0, 8'h99, 0, 8'h00);
        tick("fault_hold", E(8'h20, 1, 0, 0, 1));

        // overflow: 15 nested calls fit, the 16th faults
        do_reset("reset2");
        for (int i = 0; i < 15; i++) begin
            drv(0, 8'h00, 0, 1, 0, 8'h80 + 8'(i), 0, 8'h00);
            tick("nest_call", E(8'h80 + 8'(i), 1, 1, 1, 0));
        end
        drv(0, 8'h00, 0, 1, 0, 8'hF0, 0, 8'h00);
        tick("overflow", E(8'h8E, 1, 0, 0, 1));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        tick("ovf_hold", E(8'h8E, 1, 0, 0, 1));

        // async reset while in RET_WAIT
        do_reset("reset3");
        drv(0, 8'h00, 0, 1, 0, 8'h30, 0, 8'h00);
        tick("call30", E(8'h30, 1, 1, 1, 0));
        drv(0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00);
        tick("ret_pop2", E(8'h30, 1, 1, 0, 0));
        drv(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        now_chk("async_rst", E(8'h00, 1, 0, 0, 0));
        rst_n = 1'b1;
        tick("post_rst_run", E(8'h01, 0, 0, 0, 0));
        drv(0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00);
        tick("ret_empty", E(8'h01, 1, 0, 0, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
